// File: rtl/run_event_monitor_if.sv
// rtl/run_event_monitor_if.sv - detector-to-statistics bundle between run detector, monitor and CPU side
//
// Signals
//   det_in    detector level (high while a run of 1s persists)
//   clr       synchronous clear of statistics
//   rd_req    snapshot request strobe
//   evt_pulse 1-cycle pulse per new run
//   evt_count runs since reset/clr
//   last_len  length of most recent completed run
//   max_len   longest completed run since reset/clr
//   long_flag 1-cycle pulse when a completed run reached the threshold
//   ovf       sticky event-counter overflow
//   rd_valid  snapshot valid, 1 cycle
//   rd_count  snapshot of evt_count
// Modports
//   slave  : the monitor (drives statistics)
//   master : the side that drives det_in/clr/rd_req and reads statistics
interface run_event_monitor_if #(
  parameter int CNT_W = 8,
  parameter int LEN_W = 8
);
  logic             det_in;
  logic             clr;
  logic             rd_req;
  logic             evt_pulse;
  logic [CNT_W-1:0] evt_count;
  logic [LEN_W-1:0] last_len;
  logic [LEN_W-1:0] max_len;
  logic             long_flag;
  logic             ovf;
  logic             rd_valid;
  logic [CNT_W-1:0] rd_count;

  modport slave (
    input  det_in, clr, rd_req,
    output evt_pulse, evt_count, last_len, max_len, long_flag, ovf, rd_valid, rd_count
  );

  modport master (
    output det_in, clr, rd_req,
    input  evt_pulse, evt_count, last_len, max_len, long_flag, ovf, rd_valid, rd_count
  );
endinterface

// File: rtl/run_event_monitor.sv
// rtl/run_event_monitor.sv - run statistics (events, lengths, long-run flag, snapshot) from detector level
//
// Ports
//   clk  : system clock, all logic on posedge
//   rst  : asynchronous active-low reset
//   mon  : run_event_monitor_if.slave (det_in/clr/rd_req in, statistics out)
// Parameters
//   CNT_W  : width of event counter and snapshot
//   LEN_W  : width of saturating run-length counters
//   THRESH : run length at or above which long_flag pulses at run end
// Configuration
//   SAT_CNT_EN : evt_count saturates at all-ones instead of wrapping (ovf still sets)
module run_event_monitor #(
  parameter int CNT_W  = 8,
  parameter int LEN_W  = 8,
  parameter int THRESH = 4
) (
  input logic                 clk,
  input logic                 rst,
  run_event_monitor_if.slave  mon
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_END  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             s1_q, s2_q;
  logic [LEN_W-1:0] run_len_q, run_len_d;
  logic [CNT_W-1:0] evt_count_q, evt_count_d;
  logic [LEN_W-1:0] last_len_q, last_len_d;
  logic [LEN_W-1:0] max_len_q, max_len_d;
  logic             evt_pulse_q, evt_pulse_d;
  logic             long_flag_q, long_flag_d;
  logic             ovf_q, ovf_d;
  logic             rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0] rd_count_q, rd_count_d;

  logic             rise, fall, start, finish;
  logic [CNT_W-1:0] cnt_base;

  assign rise   = s1_q & ~s2_q;
  assign fall   = ~s1_q & s2_q;
  // A rise outside RUN opens a run; a fall inside RUN closes it.
  assign start  = rise && (state_q != S_RUN);
  assign finish = fall && (state_q == S_RUN);
  // clr takes effect first so a coinciding rise counts from zero.
  assign cnt_base = mon.clr ? '0 : evt_count_q;

  always_comb begin
    state_d     = state_q;
    run_len_d   = run_len_q;
    evt_count_d = evt_count_q;
    last_len_d  = last_len_q;
    max_len_d   = max_len_q;
    ovf_d       = ovf_q;
    evt_pulse_d = 1'b0;
    long_flag_d = 1'b0;
    rd_valid_d  = mon.rd_req;
    rd_count_d  = mon.rd_req ? evt_count_q : rd_count_q;

    case (state_q)
      S_IDLE:  if (rise) state_d = S_RUN;
      S_RUN:   if (fall) state_d = S_END;
      S_END:   state_d = rise ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (start) begin
      run_len_d = LEN_W'(1);
    end else if ((state_q == S_RUN) && s1_q && (run_len_q != '1)) begin
      run_len_d = run_len_q + LEN_W'(1);
    end

    if (mon.clr) begin
      evt_count_d = '0;
      last_len_d  = '0;
      max_len_d   = '0;
      ovf_d       = 1'b0;
    end

    if (start) begin
      evt_pulse_d = 1'b1;
      if (cnt_base == '1) begin
        ovf_d = 1'b1;
`ifdef SAT_CNT_EN
        evt_count_d = cnt_base;
`else
        evt_count_d = '0;
`endif
      end else begin
        evt_count_d = cnt_base + CNT_W'(1);
      end
    end

    if (finish) begin
      last_len_d  = run_len_q;
      max_len_d   = (mon.clr || (run_len_q > max_len_q)) ? run_len_q : max_len_q;
      long_flag_d = (run_len_q >= LEN_W'(THRESH));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      run_len_q   <= '0;
      evt_count_q <= '0;
      last_len_q  <= '0;
      max_len_q   <= '0;
      evt_pulse_q <= 1'b0;
      long_flag_q <= 1'b0;
      ovf_q       <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      s1_q        <= mon.det_in;
      s2_q        <= s1_q;
      run_len_q   <= run_len_d;
      evt_count_q <= evt_count_d;
      last_len_q  <= last_len_d;
      max_len_q   <= max_len_d;
      evt_pulse_q <= evt_pulse_d;
      long_flag_q <= long_flag_d;
      ovf_q       <= ovf_d;
      rd_valid_q  <= rd_valid_d;
      rd_count_q  <= rd_count_d;
    end
  end

  assign mon.evt_pulse = evt_pulse_q;
  assign mon.evt_count = evt_count_q;
  assign mon.last_len  = last_len_q;
  assign mon.max_len   = max_len_q;
  assign mon.long_flag = long_flag_q;
  assign mon.ovf       = ovf_q;
  assign mon.rd_valid  = rd_valid_q;
  assign mon.rd_count  = rd_count_q;

endmodule

// File: tb/tb_run_event_monitor.sv
// tb/tb_run_event_monitor.sv - randomized self-checking bench for run_event_monitor
module tb_run_event_monitor;

  localparam int THRESH = 4;
  localparam int MAXLEN = 255;
  localparam int MAXCNT = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;

  run_event_monitor_if #(.CNT_W(8), .LEN_W(8)) mon_if ();

  run_event_monitor #(.CNT_W(8), .LEN_W(8), .THRESH(THRESH)) dut (
    .clk (clk),
    .rst (rst),
    .mon (mon_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: c1/c2 are lengths of the 1-run ending at the last and
  // second-to-last sampled det_in values (0 if that sample was low).
  int m_cnt, m_last, m_max, m_rdc;
  bit m_ovf, m_pulse, m_long, m_rdv;
  int c1, c2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic compare_all();
    check("evt_pulse", {31'd0, mon_if.evt_pulse}, {31'd0, m_pulse});
    check("evt_count", {24'd0, mon_if.evt_count}, m_cnt);
    check("last_len",  {24'd0, mon_if.last_len},  m_last);
    check("max_len",   {24'd0, mon_if.max_len},   m_max);
    check("long_flag", {31'd0, mon_if.long_flag}, {31'd0, m_long});
    check("ovf",       {31'd0, mon_if.ovf},       {31'd0, m_ovf});
    check("rd_valid",  {31'd0, mon_if.rd_valid},  {31'd0, m_rdv});
    check("rd_count",  {24'd0, mon_if.rd_count},  m_rdc);
  endtask

  task automatic model_reset();
    m_cnt = 0; m_last = 0; m_max = 0; m_rdc = 0;
    m_ovf = 0; m_pulse = 0; m_long = 0; m_rdv = 0;
    c1 = 0; c2 = 0;
  endtask

  task automatic step(input bit d, input bit c, input bit r);
    bit evt, fin;
    int len;
    mon_if.det_in = d;
    mon_if.clr    = c;
    mon_if.rd_req = r;
    @(posedge clk);
    evt = (c1 > 0) && (c2 == 0);
    fin = (c1 == 0) && (c2 > 0);
    len = (c2 > MAXLEN) ? MAXLEN : c2;
    m_pulse = evt;
    m_long  = fin && (len >= THRESH);
    m_rdv   = r;
    if (r) m_rdc = m_cnt;
    if (c) begin
      m_cnt = 0; m_last = 0; m_max = 0; m_ovf = 0;
    end
    if (evt) begin
      if (m_cnt == MAXCNT) begin
        m_ovf = 1;
`ifndef SAT_CNT_EN
        m_cnt = 0;
`endif
      end else begin
        m_cnt++;
      end
    end
    if (fin) begin
      m_last = len;
      if (len > m_max) m_max = len;
    end
    c2 = c1;
    c1 = d ? c1 + 1 : 0;
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    model_reset();
    compare_all();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic run(input int len, input int gap);
    for (int i = 0; i < len; i++) step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < gap; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    mon_if.det_in = 1'b0;
    mon_if.clr    = 1'b0;
    mon_if.rd_req = 1'b0;
    #1;
    do_reset();

    // 5-cycle run then 3-cycle run
    run(0, 2);
    run(5, 3);
    check("dir5_count", {24'd0, mon_if.evt_count}, 1);
    check("dir5_last",  {24'd0, mon_if.last_len},  5);
    check("dir5_max",   {24'd0, mon_if.max_len},   5);
    run(3, 3);
    check("dir3_count", {24'd0, mon_if.evt_count}, 2);
    check("dir3_last",  {24'd0, mon_if.last_len},  3);
    check("dir3_max",   {24'd0, mon_if.max_len},   5);

    // single-cycle gaps and single-cycle runs
    run(2, 1); run(1, 1); run(4, 1); run(1, 3);

    // randomized runs with sporadic clr and frequent snapshots
    for (int r = 0; r < 150; r++) begin
      int len, gap;
      len = $urandom_range(1, 12);
      gap = $urandom_range(1, 3);
      for (int i = 0; i < len + gap; i++)
        step(i < len, $urandom_range(0, 40) == 0, $urandom_range(0, 3) == 0);
    end

    // counter overflow after 256 runs
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 256; i++) run(1, 1);
    run(0, 2);
`ifdef SAT_CNT_EN
    check("ovf_count", {24'd0, mon_if.evt_count}, 255);
`else
    check("ovf_count", {24'd0, mon_if.evt_count}, 0);
`endif
    check("ovf_flag", {31'd0, mon_if.ovf}, 1);

    // run length saturation
    run(300, 3);
    check("sat_last", {24'd0, mon_if.last_len}, 255);
    check("sat_max",  {24'd0, mon_if.max_len},  255);

    // clr coincident with rise at count 7
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) run(2, 1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("clr_rise_count", {24'd0, mon_if.evt_count}, 1);
    check("clr_rise_max",   {24'd0, mon_if.max_len},   0);
    check("clr_rise_ovf",   {31'd0, mon_if.ovf},       0);
    run(3, 2);

    // clr coincident with fall of a 5-cycle run
    run(5, 1);
    step(1'b0, 1'b1, 1'b0);
    check("clr_fall_last", {24'd0, mon_if.last_len}, 5);
    check("clr_fall_max",  {24'd0, mon_if.max_len},  5);
    run(0, 2);

    // snapshot on the increment edge, 3 -> 4
    step(1'b0, 1'b1, 1'b0);
    run(1, 1); run(1, 1); run(1, 2);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    check("rd_inc_count", {24'd0, mon_if.rd_count},  3);
    check("rd_inc_valid", {31'd0, mon_if.rd_valid},  1);
    check("rd_inc_evt",   {24'd0, mon_if.evt_count}, 4);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    check("rd_hold_valid", {31'd0, mon_if.rd_valid}, 0);
    check("rd_hold_count", {24'd0, mon_if.rd_count}, 4);

    // reset mid-run with det_in held high
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("rst_pulse", {31'd0, mon_if.evt_pulse}, 1);
    check("rst_count", {24'd0, mon_if.evt_count}, 1);
    run(2, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
